seq_pattern_generator: RTL and testbench



---
 rtl/seq_pattern_generator_if.sv | 35 +++
 rtl/seq_pattern_generator.sv | 176 +++++++++++++++++
 tb/tb_seq_pattern_generator.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_generator_if.sv
// rtl/seq_pattern_generator_if.sv - control and serial-output bundle for seq_pattern_generator
//
// Signals:
//   start     request to begin transmission (honoured only while idle)
//   abort     cancel an in-progress transmission
//   pattern   PAT_W-bit pattern, MSB sent first
//   repeat_n  number of pattern repetitions
//   P1        serial data out
//   bit_valid high while P1 carries a pattern bit
//   busy      transmission in progress
//   done      one-cycle end-of-transmission pulse
// master: the requester side; slave: the generator side.
interface seq_pattern_generator_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             P1;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_n,
        input  P1, bit_valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_n,
        output P1, bit_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_generator.sv
// rtl/seq_pattern_generator.sv - serial bit-pattern transmitter with repeat count and idle gap
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    seq_pattern_generator_if.slave: start/abort/pattern/repeat_n in,
//          P1/bit_valid/busy/done out (all outputs registered)
// Parameters:
//   PAT_W    pattern width (>= 2)
//   CNT_W    repeat count width
//   GAP_LEN  idle cycles between repetitions (0 = back-to-back)
//   IDLE_LVL level driven on P1 when no pattern bit is being sent
module seq_pattern_generator #(
    parameter int   PAT_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP_LEN  = 0,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    seq_pattern_generator_if.slave   bus
);

    localparam int BIT_W      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int GAP_W      = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam int GAP_LAST_I = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LAST_I);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [CNT_W-1:0] PASS_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // shreg holds the pattern with the bit currently on P1 at its MSB.
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic p1_q, p1_d;
    logic valid_q, valid_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            pat_q      <= '0;
            bit_cnt_q  <= '0;
            pass_cnt_q <= '0;
            gap_cnt_q  <= '0;
            p1_q       <= IDLE_LVL;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            pat_q      <= pat_d;
            bit_cnt_q  <= bit_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            p1_q       <= p1_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Output registers are loaded with the values belonging to the state
    // being entered, so each state's outputs appear in the cycle it occupies.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        pat_d      = pat_q;
        bit_cnt_d  = bit_cnt_q;
        pass_cnt_d = pass_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        p1_d       = IDLE_LVL;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    pat_d      = bus.pattern;
                    shreg_d    = bus.pattern;
                    pass_cnt_d = bus.repeat_n;
                    bit_cnt_d  = '0;
                    gap_cnt_d  = '0;
                    if (bus.repeat_n == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        p1_d    = bus.pattern[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bit_cnt_q != BIT_LAST) begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                    shreg_d   = shreg_q << 1;
                    p1_d      = shreg_q[PAT_W-2];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    // Last bit of this pass is on the line now.
                    bit_cnt_d  = '0;
                    pass_cnt_d = pass_cnt_q - PASS_ONE;
                    if (pass_cnt_q == PASS_ONE) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (GAP_LEN > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = '0;
                        busy_d    = 1'b1;
                    end else begin
                        shreg_d = pat_q;
                        p1_d    = pat_q[PAT_W-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            GAP: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_LAST) begin
                    state_d   = SHIFT;
                    gap_cnt_d = '0;
                    shreg_d   = pat_q;
                    p1_d      = pat_q[PAT_W-1];
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_ONE;
                    busy_d    = 1'b1;
                end
            end

            FIN: begin
                // done is already on the output; abort here cannot retract it.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.P1        = p1_q;
    assign bus.bit_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_pattern_generator.sv
// tb/tb_seq_pattern_generator.sv - self-checking bench for seq_pattern_generator
module tb_seq_pattern_generator;

    localparam int   PAT_W  = 4;
    localparam int   CNT_W  = 4;
    localparam int   GAP_A  = 2;
    localparam int   GAP_B  = 0;
    localparam logic IDLE_A = 1'b0;
    localparam logic IDLE_B = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic [CNT_W-1:0] repeat_n = '0;

    int checks = 0;
    int errors = 0;

    seq_pattern_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_a ();
    seq_pattern_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.start    = start;
    assign bus_a.abort    = abort;
    assign bus_a.pattern  = pattern;
    assign bus_a.repeat_n = repeat_n;
    assign bus_b.start    = start;
    assign bus_b.abort    = abort;
    assign bus_b.pattern  = pattern;
    assign bus_b.repeat_n = repeat_n;

    seq_pattern_generator #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_A), .IDLE_LVL(IDLE_A)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    seq_pattern_generator #(
        .PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_LEN(GAP_B), .IDLE_LVL(IDLE_B)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    // Expected {P1, bit_valid, busy, done} in cycle k after the start sample.
    function automatic logic [3:0] model(input int k, input logic [PAT_W-1:0] pat,
                                         input int r, input int gap, input logic idle);
        int per;
        int len;
        int pos;
        logic [3:0] o;
        per = PAT_W + gap;
        len = (r == 0) ? 0 : r * PAT_W + (r - 1) * gap;
        o = {idle, 3'b000};
        if (k >= 1 && k <= len) begin
            pos = (k - 1) % per;
            o[1] = 1'b1;
            if (pos < PAT_W) begin
                o[3] = pat[PAT_W-1-pos];
                o[2] = 1'b1;
            end
        end else if (k == len + 1) begin
            o[0] = 1'b1;
        end
        return o;
    endfunction

    function automatic int seq_len(input int r, input int gap);
        return (r == 0) ? 0 : r * PAT_W + (r - 1) * gap;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed={P1,valid,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input int k, input logic [PAT_W-1:0] pat, input int r);
        chk($sformatf("%s k=%0d gap%0d", tag, k, GAP_A),
            {bus_a.P1, bus_a.bit_valid, bus_a.busy, bus_a.done}, model(k, pat, r, GAP_A, IDLE_A));
        chk($sformatf("%s k=%0d gap%0d", tag, k, GAP_B),
            {bus_b.P1, bus_b.bit_valid, bus_b.busy, bus_b.done}, model(k, pat, r, GAP_B, IDLE_B));
    endtask

    // Idle check: k=0 lies outside every transmission window.
    task automatic chk_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk_both(tag, 0, '0, 1);
            tick;
        end
    endtask

    // One full transmission; with noise, pattern/repeat_n wiggle every cycle
    // and start is re-pulsed randomly while both generators are still busy.
    task automatic run(input string tag, input logic [PAT_W-1:0] pat, input int r, input bit noise);
        int len_a;
        int len_b;
        len_a = seq_len(r, GAP_A);
        len_b = seq_len(r, GAP_B);
        pattern  = pat;
        repeat_n = CNT_W'(r);
        start    = 1'b1;
        abort    = 1'b0;
        tick;
        for (int k = 1; k <= len_a + 2; k++) begin
            chk_both(tag, k, pat, r);
            start = 1'b0;
            if (noise) begin
                pattern  = PAT_W'($urandom);
                repeat_n = CNT_W'($urandom);
                if (k <= len_b + 1) start = 1'($urandom_range(0, 1));
            end
            tick;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [PAT_W-1:0] p;
        reset = 1'b1;
        tick;
        tick;
        chk_both("reset_state", 0, '0, 1);
        reset = 1'b0;
        tick;
        chk_both("post_reset_idle", 0, '0, 1);

        run("single_1101", 4'b1101, 1, 1'b0);
        run("repeat_1101", 4'b1101, 2, 1'b0);
        run("b2b_1011", 4'b1011, 3, 1'b0);
        run("zero_count", 4'b1010, 0, 1'b0);
        run("max_count", 4'b1001, 15, 1'b1);

        // Abort with an ignored second start.
        pattern  = 4'b1111;
        repeat_n = 4'd2;
        start    = 1'b1;
        tick;
        start = 1'b0;
        chk_both("abort_seq", 1, 4'b1111, 2);
        tick;
        chk_both("abort_seq", 2, 4'b1111, 2);
        pattern = 4'b0000;
        start   = 1'b1;
        tick;
        start = 1'b0;
        chk_both("abort_seq", 3, 4'b1111, 2);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk_idle("after_abort", 20);

        // Start and abort together in IDLE.
        pattern  = 4'b1011;
        repeat_n = 4'd1;
        start    = 1'b1;
        abort    = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk_idle("start_abort_idle", 8);

        // Reset during a gap cycle of the gapped generator.
        p        = PAT_W'($urandom);
        pattern  = p;
        repeat_n = 4'd3;
        start    = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk_both("pre_reset", k, p, 3);
            if (k < 5) tick;
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_idle("reset_mid_gap", 20);
        run("fresh_after_reset", PAT_W'($urandom), $urandom_range(1, 15), 1'b1);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("rand%0d", i), PAT_W'($urandom), $urandom_range(0, 15), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
